demux1to4_reg: RTL and testbench
================================

// Module: demux1to4_reg
// PURPOSE
//  Registered 1-to-4 stream demultiplexer: the routing counterpart of the 4:1 muxes.
//  One input stream plus a 2-bit select steers each word to one of four output channels.
//  Each channel holds a 1-entry register with valid/ready handshake.
//  Sits between a single producer and four independent consumers.
// PARAMETERS
//  DW   8   data width of input word and of each output channel
// PORTS
//  clk        in   1      system clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      producer presents in_data/sel
//  in_ready   out  1      block accepts word this cycle (combinational)
//  in_data    in   DW     input word
//  sel        in   2      destination channel 0..3, sampled with in_data
//  out_valid  out  4      bit i: channel i register holds a word
//  out_ready  in   4      bit i: consumer i takes word this cycle
//  out_data   out  4*DW   channel i data = out_data[i*DW +: DW]
//  xfer_cnt   out  64     only with DEMUX_STAT_EN; see CONFIGURATION
// BEHAVIOUR
//  - One clock (clk); reset is asynchronous and active-high (rst).
//  - Reset (async assert, any time incl. mid-transfer): out_valid=4'b0000, out_data=0,
//    xfer_cnt=0; words held in channels are discarded; in_ready follows the rule below
//    (=1 once rst is low, since all channels are empty).
//  - Per channel i: full[i] = out_valid[i]. pop[i] = out_valid[i] & out_ready[i].
//  - in_ready = ~full[sel] | out_ready[sel]  (pure function of sel, state, out_ready).
//  - push = in_valid & in_ready; pushes go to channel sel only.
//  - Latency: word accepted at edge N appears on out_data[sel], out_valid[sel]=1 after edge N.
//  - Channel update at each edge:
//      push & ~pop  -> load in_data, valid<=1
//      push & pop   -> load in_data, valid stays 1 (back-to-back, no bubble)
//      ~push & pop  -> valid<=0, data holds last value
//      neither      -> hold
//  - Channels are independent: pops on any channel never block pushes to another.
//  - Full channel with out_ready low: in_ready=0 for that sel; producer must hold
//    in_valid/in_data/sel stable until accepted; other sel values may be presented instead.
//  - in_valid=0: in_ready value is don't-care to producer, no state change on push path.
//  - out_data of a non-valid channel holds last value; consumers ignore it.
//  - Throughput: one word per cycle sustained when target consumer keeps out_ready=1.
// CONFIGURATION
//  - Macro DEMUX_STAT_EN:
//    defined: port xfer_cnt present; 4 x 16-bit counters, channel i = xfer_cnt[i*16 +: 16],
//      +1 on each push to channel i, wraps 16'hFFFF -> 16'h0000, cleared by rst.
//    undefined: xfer_cnt port and counters absent; all other behaviour identical.
// TESTING
//  1 rst=1 mid-stream with out_valid=4'b0101 -> out_valid=0, out_data=0 immediately
//    (async), in_ready=1 after release.
//  2 DW=8: push 8'hA5 sel=2, out_ready=0 -> next cycle out_valid=4'b0100,
//    out_data[23:16]=8'hA5; second push sel=2 -> in_ready=0, channel keeps 8'hA5.
//  3 Channel 1 full, out_ready[1]=1, push 8'h3C sel=1 same cycle -> in_ready=1,
//    out_data[15:8]=8'h3C, out_valid[1] stays 1.
//  4 Channel 0 stalled full; push 8'h11 sel=3 -> accepted, out_valid=4'b1001.
//  5 Stream 0x00..0x07 with sel=i%4, all out_ready=1 -> one word/cycle, each channel
//    receives its words in order, no loss or duplication.
//  6 DEMUX_STAT_EN: 65537 pushes to channel 0 -> xfer_cnt[15:0]=16'h0001,
//    other counters 0; rst clears all to 0.

Source files
------------

// File: rtl/demux1to4_reg.sv
// rtl/demux1to4_reg.sv - registered 1-to-4 stream demux, one-entry register per channel
// Optional per-channel push counters on xfer_cnt when DEMUX_STAT_EN is defined.
module demux1to4_reg #(
   parameter int DW = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [DW-1:0]   in_data,
   input  logic [1:0]      sel,
   output logic [3:0]      out_valid,
   input  logic [3:0]      out_ready,
   output logic [4*DW-1:0] out_data
`ifdef DEMUX_STAT_EN
   ,
   output logic [63:0]     xfer_cnt
`endif
);

   logic [3:0]      valid_q, valid_d;
   logic [4*DW-1:0] data_q, data_d;
   logic [3:0]      pop;
   logic [3:0]      push_vec;
   logic            push;

   // A full channel can still accept when its consumer drains it in the same cycle.
   assign in_ready = ~valid_q[sel] | out_ready[sel];
   assign push     = in_valid & in_ready;
   assign push_vec = push ? (4'd1 << sel) : 4'd0;
   assign pop      = valid_q & out_ready;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      for (int i = 0; i < 4; i++) begin
         if (push_vec[i]) begin
            valid_d[i]           = 1'b1;
            data_d[i*DW +: DW]   = in_data;
         end else if (pop[i]) begin
            valid_d[i]           = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 4'd0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign out_valid = valid_q;
   assign out_data  = data_q;

`ifdef DEMUX_STAT_EN
   logic [63:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      for (int i = 0; i < 4; i++) begin
         if (push_vec[i]) begin
            cnt_d[i*16 +: 16] = cnt_q[i*16 +: 16] + 16'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= 64'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign xfer_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_demux1to4_reg.sv
// tb/tb_demux1to4_reg.sv - self-checking bench for demux1to4_reg
// Queue-based channel model, constant vector table, random traffic, reset and counter sequences.
module tb_demux1to4_reg;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_data;
   logic [1:0]  sel;
   logic [3:0]  out_valid;
   logic [3:0]  out_ready;
   logic [31:0] out_data;
`ifdef DEMUX_STAT_EN
   logic [63:0] xfer_cnt;
`endif

   int checks = 0;
   int errors = 0;

   demux1to4_reg #(.DW(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .sel       (sel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
`ifdef DEMUX_STAT_EN
      ,
      .xfer_cnt  (xfer_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Each channel is a queue of capacity one; last[] is the word most recently written.
   logic [7:0] mq [4][$];
   logic [7:0] last [4];
   int         mcnt [4];

   typedef struct {
      logic        iv;
      logic [7:0]  d;
      logic [1:0]  s;
      logic [3:0]  r;
      logic        exp_rdy;
      logic [3:0]  exp_valid;
      logic [31:0] exp_data;
   } vec_t;

   vec_t vt [9];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < 4; c++) begin
         mq[c].delete();
         last[c] = 8'h00;
         mcnt[c] = 0;
      end
   endtask

   function automatic logic [3:0] m_valid();
      logic [3:0] v;
      for (int c = 0; c < 4; c++) v[c] = (mq[c].size() > 0);
      return v;
   endfunction

   function automatic logic [31:0] m_data();
      return {last[3], last[2], last[1], last[0]};
   endfunction

   // Called at posedge+1; returns at the next posedge+1 with state checked.
   task automatic cycle(input logic iv, input logic [7:0] d, input logic [1:0] s,
                        input logic [3:0] r);
      logic exp_rdy;
      logic do_push;
      in_valid  = iv;
      in_data   = d;
      sel       = s;
      out_ready = r;
      #1;
      exp_rdy = (mq[s].size() == 0) || r[s];
      chk("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
      do_push = iv && exp_rdy;
      @(posedge clk);
      for (int c = 0; c < 4; c++) begin
         if (r[c] && mq[c].size() > 0) void'(mq[c].pop_front());
      end
      if (do_push) begin
         mq[s].push_back(d);
         last[s] = d;
         mcnt[s] = (mcnt[s] + 1) % 65536;
      end
      #1;
      chk("out_valid", {60'd0, out_valid}, {60'd0, m_valid()});
      chk("out_data", {32'd0, out_data}, {32'd0, m_data()});
`ifdef DEMUX_STAT_EN
      chk("xfer_cnt", xfer_cnt, {mcnt[3][15:0], mcnt[2][15:0], mcnt[1][15:0], mcnt[0][15:0]});
`endif
   endtask

   task automatic do_reset();
      in_valid  = 1'b0;
      out_ready = 4'd0;
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      chk("rst_out_valid", {60'd0, out_valid}, 64'd0);
      chk("rst_out_data", {32'd0, out_data}, 64'd0);
`ifdef DEMUX_STAT_EN
      chk("rst_xfer_cnt", xfer_cnt, 64'd0);
`endif
      #3;
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      sel       = 2'd0;
      out_ready = 4'd0;
      model_reset();
      #12;
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("reset_valid", {60'd0, out_valid}, 64'd0);
      chk("reset_data", {32'd0, out_data}, 64'd0);

      //             iv    d      s     r        rdy   valid    data
      vt[0] = '{1'b1, 8'hA5, 2'd2, 4'b0000, 1'b1, 4'b0100, 32'h00A50000};
      vt[1] = '{1'b1, 8'h5A, 2'd2, 4'b0000, 1'b0, 4'b0100, 32'h00A50000};
      vt[2] = '{1'b1, 8'h77, 2'd1, 4'b0000, 1'b1, 4'b0110, 32'h00A57700};
      vt[3] = '{1'b1, 8'h3C, 2'd1, 4'b0010, 1'b1, 4'b0110, 32'h00A53C00};
      vt[4] = '{1'b0, 8'h00, 2'd0, 4'b0110, 1'b1, 4'b0000, 32'h00A53C00};
      vt[5] = '{1'b1, 8'h99, 2'd0, 4'b0000, 1'b1, 4'b0001, 32'h00A53C99};
      vt[6] = '{1'b1, 8'h22, 2'd0, 4'b0000, 1'b0, 4'b0001, 32'h00A53C99};
      vt[7] = '{1'b1, 8'h11, 2'd3, 4'b0000, 1'b1, 4'b1001, 32'h11A53C99};
      vt[8] = '{1'b0, 8'h00, 2'd0, 4'b1111, 1'b1, 4'b0000, 32'h11A53C99};

      for (int k = 0; k < 9; k++) begin
         logic rdy_seen;
         in_valid  = vt[k].iv;
         in_data   = vt[k].d;
         sel       = vt[k].s;
         out_ready = vt[k].r;
         #1;
         rdy_seen = in_ready;
         #1;
         cycle(vt[k].iv, vt[k].d, vt[k].s, vt[k].r);
         chk($sformatf("vec%0d_rdy", k), {63'd0, rdy_seen}, {63'd0, vt[k].exp_rdy});
         chk($sformatf("vec%0d_valid", k), {60'd0, out_valid}, {60'd0, vt[k].exp_valid});
         chk($sformatf("vec%0d_data", k), {32'd0, out_data}, {32'd0, vt[k].exp_data});
      end

      // Asynchronous reset with channels 0 and 2 holding words.
      cycle(1'b1, 8'h01, 2'd0, 4'b0000);
      cycle(1'b1, 8'h02, 2'd2, 4'b0000);
      chk("pre_rst_valid", {60'd0, out_valid}, 64'h5);
      do_reset();
      for (int s = 0; s < 4; s++) begin
         sel = 2'(s);
         #1;
         chk("post_rst_ready", {63'd0, in_ready}, 64'd1);
      end
      @(posedge clk);
      #1;

      // Streaming with all consumers ready: every word must be accepted.
      for (int k = 0; k < 8; k++) begin
         cycle(1'b1, 8'(k), 2'(k % 4), 4'b1111);
      end
      cycle(1'b0, 8'h00, 2'd0, 4'b1111);

      for (int k = 0; k < 400; k++) begin
         cycle(1'($urandom_range(0, 3) != 0), 8'($urandom), 2'($urandom),
               4'($urandom));
      end

`ifdef DEMUX_STAT_EN
      do_reset();
      for (int k = 0; k < 65537; k++) begin
         cycle(1'b1, 8'(k), 2'd0, 4'b1111);
      end
      chk("cnt_wrap", xfer_cnt, 64'h0000_0000_0000_0001);
      do_reset();
      chk("cnt_cleared", xfer_cnt, 64'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
